// File: rtl/clks_alot_p.sv
// ---------------------------------------------------------------------------
// clks_alot_p
// Types shared by the clks_alot event generator and its receive-side
// counterpart event_recovery.
//   generated_events_s : the four single-cycle clock event pulses
//   recovery_state_e   : event_recovery lock state
//   MIN_SYNC_STAGES    : smallest usable input synchronizer depth
// ---------------------------------------------------------------------------
package clks_alot_p;

   typedef struct packed {
      logic rising_edge;
      logic stable_high;
      logic falling_edge;
      logic stable_low;
   } generated_events_s;

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      MEASURE,
      LOCKED
   } recovery_state_e;

   localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/common_p.sv
// ---------------------------------------------------------------------------
// common_p
// Shared clock-domain bundle used across the system.
//   clk_dom_s.clk      : domain clock
//   clk_dom_s.sync_rst : synchronous, active-high reset for that domain
// ---------------------------------------------------------------------------
package common_p;

   typedef struct packed {
      logic clk;
      logic sync_rst;
   } clk_dom_s;

endpackage

// File: rtl/recovery_synchronizer.sv
// ---------------------------------------------------------------------------
// recovery_synchronizer
// Brings an asynchronous clock-like input into the clk domain through a
// flop chain, then compares the synced level against its own previous
// value to flag transitions.
// Ports:
//   clk    : system clock
//   din    : asynchronous input level
//   level  : synchronized level
//   rise   : synced level went 0->1 this cycle (combinational)
//   fall   : synced level went 1->0 this cycle (combinational)
// ---------------------------------------------------------------------------
module recovery_synchronizer
   import clks_alot_p::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic clk,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // Depths below the metastability minimum are raised to it.
   localparam int DEPTH = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

   logic [DEPTH-1:0] chain;
   logic             prev;

   always_ff @(posedge clk) begin
      chain <= {chain[DEPTH-2:0], din};
      prev  <= chain[DEPTH-1];
   end

   assign level = chain[DEPTH-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/event_recovery.sv
// ---------------------------------------------------------------------------
// event_recovery
// Recovers the clks_alot event bundle from an externally driven clock.
// The input is synchronized, its high and low phases are timed in system
// cycles, and rising_edge / stable_high / falling_edge / stable_low are
// emitted as single-cycle registered pulses. Stable events mark the
// midpoint of a phase, predicted from the previous measurement of it.
// Ports:
//   sys_dom_i      : system clock and synchronous active-high reset
//   recovery_en_i  : enable; low returns to IDLE and clears all outputs
//   io_clk_i       : external clock, asynchronous to the system clock
//   idle_timeout_i : edge-free cycles before clock loss (0 disables)
//   clk_events_o   : recovered event pulses
//   clock_active_o : clock seen (MEASURE or LOCKED)
//   period_valid_o : both phase lengths measured (LOCKED)
//   high_period_o  : last measured high-phase length in cycles
//   low_period_o   : last measured low-phase length in cycles
// ---------------------------------------------------------------------------
module event_recovery
   import common_p::*;
   import clks_alot_p::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int COUNTER_WIDTH = 16
)(
   input  clk_dom_s                 sys_dom_i,
   input  logic                     recovery_en_i,
   input  logic                     io_clk_i,
   input  logic [COUNTER_WIDTH-1:0] idle_timeout_i,
   output generated_events_s        clk_events_o,
   output logic                     clock_active_o,
   output logic                     period_valid_o,
   output logic [COUNTER_WIDTH-1:0] high_period_o,
   output logic [COUNTER_WIDTH-1:0] low_period_o
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic clk;
   logic rst;
   assign clk = sys_dom_i.clk;
   assign rst = sys_dom_i.sync_rst;

   logic level;
   logic rise;
   logic fall;

   recovery_synchronizer #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .din   (io_clk_i),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   recovery_state_e          state;
   logic [COUNTER_WIDTH-1:0] count;
   logic [COUNTER_WIDTH-1:0] count_inc;
   logic                     got_high;
   logic                     got_low;
   logic                     edge_seen;
   logic                     timeout_hit;
   logic                     stable_high_hit;
   logic                     stable_low_hit;

   function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // count_inc is both the counter's next value when no edge occurs and
   // the phase length (count+1, saturated) captured when one does.
   // Stable events compare against count_inc so the registered pulse lands
   // in the cycle whose counter equals the midpoint.
   always_comb begin
      count_inc       = sat_inc(count);
      edge_seen       = rise | fall;
      timeout_hit     = !edge_seen && (idle_timeout_i != '0) && (count_inc >= idle_timeout_i);
      stable_high_hit = level && (high_period_o[COUNTER_WIDTH-1:1] != '0) &&
                        (count_inc == (high_period_o >> 1));
      stable_low_hit  = !level && (low_period_o[COUNTER_WIDTH-1:1] != '0) &&
                        (count_inc == (low_period_o >> 1));
   end

   always_ff @(posedge clk) begin
      if (rst || !recovery_en_i) begin
         state          <= IDLE;
         count          <= '0;
         got_high       <= 1'b0;
         got_low        <= 1'b0;
         clk_events_o   <= '0;
         clock_active_o <= 1'b0;
         period_valid_o <= 1'b0;
         high_period_o  <= '0;
         low_period_o   <= '0;
      end else begin
         clk_events_o <= '0;
         count        <= edge_seen ? '0 : count_inc;
         case (state)
            IDLE: begin
               // The synchronizer's prev register already tracks the synced
               // level here, so the first ACQUIRE cycle sees no stale edge.
               state <= ACQUIRE;
               count <= '0;
            end
            ACQUIRE, MEASURE, LOCKED: begin
               if (edge_seen) begin
                  clk_events_o.rising_edge  <= rise;
                  clk_events_o.falling_edge <= fall;
                  if (state == ACQUIRE) begin
                     // First edge only establishes phase; nothing to measure yet.
                     state          <= MEASURE;
                     got_high       <= 1'b0;
                     got_low        <= 1'b0;
                     clock_active_o <= 1'b1;
                  end else begin
                     if (rise) begin
                        low_period_o <= count_inc;
                        got_low      <= 1'b1;
                     end else begin
                        high_period_o <= count_inc;
                        got_high      <= 1'b1;
                     end
                     if ((state == MEASURE) && ((rise && got_high) || (fall && got_low))) begin
                        state          <= LOCKED;
                        period_valid_o <= 1'b1;
                     end
                  end
               end else if (timeout_hit) begin
                  // Clock lost: drop status but keep the last measurements.
                  state          <= ACQUIRE;
                  clock_active_o <= 1'b0;
                  period_valid_o <= 1'b0;
               end else if (state == LOCKED) begin
                  clk_events_o.stable_high <= stable_high_hit;
                  clk_events_o.stable_low  <= stable_low_hit;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/event_recovery.md
Name: event_recovery

Overview:
Receive-side counterpart to the clks_alot event generator. It samples an externally driven clock into the system domain and measures its high and low phase lengths in system cycles. It then produces the same four-event bundle (rising_edge, stable_high, falling_edge, stable_low) as single-cycle pulses, which lets downstream logic treat a received clock exactly like a locally generated one.

Parameters:
SYNC_STAGES, 2, flop stages in the input synchronizer (min 2)
COUNTER_WIDTH, 16, width of the phase counter and of the measured-period outputs

Ports:
sys_dom_i  input  common_p::clk_dom_s  system clock domain bundle; one clock (clk), reset sync_rst is synchronous, active-high
recovery_en_i  input  1  enables recovery; low forces IDLE
io_clk_i  input  1  external clock, asynchronous to sys clk
idle_timeout_i  input  COUNTER_WIDTH  cycles without an edge before loss of clock; 0 disables the timeout
clk_events_o  output  clks_alot_p::generated_events_s  recovered event pulses
clock_active_o  output  1  high in MEASURE and LOCKED
period_valid_o  output  1  high in LOCKED only
high_period_o  output  COUNTER_WIDTH  last measured high-phase length, in cycles
low_period_o  output  COUNTER_WIDTH  last measured low-phase length, in cycles

Behaviour:
- Reset or recovery_en_i=0: state=IDLE; every event field, clock_active_o, period_valid_o, high_period_o, low_period_o = 0; phase counter = 0.
- Synchronizer: SYNC_STAGES flops, then a prev register. An edge is a synced value different from prev.
  - rising_edge / falling_edge pulse for exactly 1 cycle, in the cycle after the synced value changes.
  - Latency from a sampled io_clk_i transition to the pulse is SYNC_STAGES+1 cycles.
- Phase counter:
  - Cleared to 0 in the edge-pulse cycle.
  - Otherwise increments by 1 per cycle and saturates at all-ones (no wrap).
- Period capture, in the edge-pulse cycle, where count is the value before clearing:
  - On a rising edge: low_period_o <= count+1.
  - On a falling edge: high_period_o <= count+1.
  - Capture saturates at all-ones.
- States and transitions:
  - IDLE -> ACQUIRE when recovery_en_i=1. On entry to ACQUIRE, prev is loaded from the synced value so that no false edge is produced.
  - ACQUIRE -> MEASURE on the first edge. That edge's pulse is emitted, but no period is captured from it.
  - MEASURE -> LOCKED once both a high period and a low period have been captured since entering MEASURE.
  - LOCKED stays locked on every subsequent edge.
  - Any state except IDLE -> ACQUIRE if idle_timeout_i != 0 and counter >= idle_timeout_i. In that cycle clock_active_o and period_valid_o drop; measured periods hold their last values.
  - Any state -> IDLE on reset or recovery_en_i=0, taking effect the next cycle.
- Stable events (LOCKED only):
  - stable_high pulses when the synced level=1 and counter == high_period_o>>1.
  - stable_low pulses when the synced level=0 and counter == low_period_o>>1.
  - Each fires at most once per phase.
  - Suppressed when the relevant period < 2, because the midpoint would coincide with the edge.
  - If an edge and a stable condition fall in the same cycle, the edge wins and the stable event is dropped.
  - Stable events use the previous measurement of that phase, so jitter shifts the midpoint by the measurement error.
- Event exclusivity: at most one event field is high in any cycle.
- Edge pulses are emitted in ACQUIRE, MEASURE and LOCKED, and never in IDLE.

Decomposition:
- clks_alot_p receives:
  - the recovery_state_e enum {IDLE, ACQUIRE, MEASURE, LOCKED};
  - a localparam for the minimum SYNC_STAGES.
- generated_events_s is reused unchanged.
- One sub-module, recovery_synchronizer: the SYNC_STAGES flop chain plus the prev register, producing the synced level, rise pulse and fall pulse.
- Counter, capture and FSM stay in event_recovery.

Test Plan:
- Reset, then enable with io_clk_i toggling 8 high / 8 low cycles, idle_timeout_i=100:
  - rising_edge and falling_edge pulses are 8 cycles apart, arriving SYNC_STAGES+1 cycles after each transition;
  - after one full high+low, high_period_o=8, low_period_o=8 and period_valid_o=1;
  - stable_high fires 4 cycles after each rising_edge and stable_low 4 cycles after each falling_edge.
- Asymmetric 3 high / 12 low:
  - high_period_o=3 and low_period_o=12;
  - stable_high fires 1 cycle after rising_edge and stable_low 6 cycles after falling_edge.
- Clock stops high with idle_timeout_i=20:
  - 20 cycles after the last edge, state=ACQUIRE and clock_active_o=period_valid_o=0;
  - no events until the next edge, which emits falling_edge and enters MEASURE.
- 1 high / 1 low toggling:
  - edge pulses alternate every cycle, periods=1/1 and LOCKED;
  - no stable_high or stable_low ever fires.
- recovery_en_i deasserted mid-LOCKED:
  - the next cycle has all outputs 0 and state IDLE;
  - re-enable re-acquires with no spurious edge pulse in the first cycle.
- idle_timeout_i=0 with io_clk_i held for 70000 cycles:
  - no timeout occurs;
  - the counter saturates at 0xFFFF;
  - the next edge captures period 0xFFFF.
